// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader_if
//
// Purpose:
//   Bitstream word stream feeding the configuration-chain loader. A word is
//   transferred on every prog_clk edge where word_valid and word_ready are
//   both high.
//
// Signals:
//   word_data   bitstream word, MSB is the first bit shifted into the chain
//   word_valid  producer has a word on word_data
//   word_ready  loader accepts the word this cycle
//
// Modports:
//   master  bitstream producer (drives data/valid, observes ready)
//   slave   loader side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);

    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Purpose:
//   Serial loader for the configuration-chain flops of I/O and logic tiles.
//   Bitstream words arrive over a valid/ready stream and are shifted into the
//   chain head one bit per enabled prog_clk cycle, MSB first. The loader also
//   produces the clock enable that gates the chain's programming clock, so the
//   chain only moves while a bit is actually being presented. An optional
//   verify pass recirculates the loaded pattern from a shadow copy and checks
//   the chain tail against it, leaving the chain holding the same pattern.
//
// Parameters:
//   CHAIN_LEN  number of configuration flops in the chain (>= 2)
//   WORD_W     bitstream word width (>= 1)
//   CNT_W      bit counter width, derived from CHAIN_LEN; leave at default
//
// Ports:
//   prog_clk    programming clock, all state updates on its rising edge
//   pReset      synchronous active-high reset
//   start       one-cycle pulse starting a load, honoured only when idle
//   verify_en   sampled together with start, requests a verify pass
//   word_if     bitstream word stream (slave side)
//   ccff_head   registered serial data to the chain head
//   ccff_tail   chain tail (output of the last configuration flop)
//   cfg_clk_en  registered; chain shifts at the end of a cycle where it is 1
//   busy        loader is not idle
//   done        one-cycle pulse when the whole sequence has completed
//   error       sticky verify mismatch flag, cleared by an accepted start
//   bits_sent   number of bits shifted in the current pass
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic               prog_clk,
    input  logic [0:0]         pReset,
    input  logic               start,
    input  logic               verify_en,
    ccff_chain_loader_if.slave word_if,
    output logic [0:0]         ccff_head,
    input  logic [0:0]         ccff_tail,
    output logic               cfg_clk_en,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   bits_sent
);

    // Wide enough to hold a full word's worth of remaining bits.
    localparam int LEFT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [WORD_W-1:0]     buf_q,      buf_d;
    logic [CHAIN_LEN-1:0]  shadow_q,   shadow_d;
    logic [LEFT_W-1:0]     wordLeft_q, wordLeft_d;
    logic [CNT_W-1:0]      bitsSent_q, bitsSent_d;
    logic                  verify_q,   verify_d;
    logic                  error_q,    error_d;
    logic                  head_q,     head_d;
    logic                  en_q,       en_d;

    // Shadow contents after the bit currently on ccff_head has been recorded;
    // the oldest bit (the first one shifted) sits in the MSB once full.
    logic [CHAIN_LEN-1:0]  shadowPush;
    // Chain bits still missing when a new word is accepted.
    logic [CNT_W-1:0]      bitsRemaining;
    // The bit on ccff_head this cycle is the last one of the current pass.
    logic                  lastBit;

    assign shadowPush    = {shadow_q[CHAIN_LEN-2:0], head_q};
    assign bitsRemaining = CNT_W'(CHAIN_LEN) - bitsSent_q;
    assign lastBit       = (bitsSent_q == CNT_W'(CHAIN_LEN - 1));

    // State and datapath registers. Reset is synchronous so an abort takes
    // effect on the next edge and the chain enable drops straight away.
    always_ff @(posedge prog_clk) begin
        if (pReset[0]) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            shadow_q   <= '0;
            wordLeft_q <= '0;
            bitsSent_q <= '0;
            verify_q   <= 1'b0;
            error_q    <= 1'b0;
            head_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            shadow_q   <= shadow_d;
            wordLeft_q <= wordLeft_d;
            bitsSent_q <= bitsSent_d;
            verify_q   <= verify_d;
            error_q    <= error_d;
            head_q     <= head_d;
            en_q       <= en_d;
        end
    end

    // Next-state logic. ccff_head and cfg_clk_en are registered, so every
    // transition into a shifting cycle prepares the bit for that cycle here:
    // head_d/en_d describe what the chain sees during the next cycle. Any
    // path that does not explicitly request a shift leaves the enable low,
    // which keeps the chain frozen while waiting for words or when finished.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        shadow_d   = shadow_q;
        wordLeft_d = wordLeft_q;
        bitsSent_d = bitsSent_q;
        verify_d   = verify_q;
        error_d    = error_q;
        head_d     = 1'b0;
        en_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    verify_d   = verify_en;
                    error_d    = 1'b0;
                    bitsSent_d = '0;
                end
            end

            FETCH: begin
                if (word_if.word_valid) begin
                    // The MSB goes out immediately; the buffer keeps the rest
                    // left-aligned so its MSB is always the next bit to send.
                    head_d = word_if.word_data[WORD_W-1];
                    buf_d  = word_if.word_data << 1;
                    en_d   = 1'b1;
                    // The final word may be only partly needed; its surplus
                    // LSBs are never shifted out.
                    if (int'(bitsRemaining) < WORD_W) begin
                        wordLeft_d = LEFT_W'(bitsRemaining);
                    end else begin
                        wordLeft_d = LEFT_W'(WORD_W);
                    end
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                shadow_d   = shadowPush;
                bitsSent_d = bitsSent_q + 1'b1;
                wordLeft_d = wordLeft_q - 1'b1;
                if (lastBit) begin
                    if (verify_q) begin
                        // Start recirculating at once: present the oldest
                        // recorded bit and rotate it to the back so the
                        // shadow MSB is always the bit for the cycle after.
                        state_d    = VERIFY;
                        bitsSent_d = '0;
                        head_d     = shadowPush[CHAIN_LEN-1];
                        shadow_d   = {shadowPush[CHAIN_LEN-2:0],
                                      shadowPush[CHAIN_LEN-1]};
                        en_d       = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else if (wordLeft_q == LEFT_W'(1)) begin
                    state_d = FETCH;
                end else begin
                    head_d = buf_q[WORD_W-1];
                    buf_d  = buf_q << 1;
                    en_d   = 1'b1;
                end
            end

            VERIFY: begin
                // The tail-most flop holds exactly the bit being pushed back
                // in at the head, so any difference means the chain did not
                // retain what was loaded.
                if (ccff_tail[0] != head_q) begin
                    error_d = 1'b1;
                end
                bitsSent_d = bitsSent_q + 1'b1;
                if (lastBit) begin
                    state_d = DONE;
                end else begin
                    head_d   = shadow_q[CHAIN_LEN-1];
                    shadow_d = {shadow_q[CHAIN_LEN-2:0], shadow_q[CHAIN_LEN-1]};
                    en_d     = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign word_if.word_ready = (state_q == FETCH);
    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);
    assign error              = error_q;
    assign ccff_head          = head_q;
    assign cfg_clk_en         = en_q;
    assign bits_sent          = bitsSent_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Drives two loader instances sharing one clock: an 8-flop chain (8-bit
// words) and a 12-flop chain (8-bit words, last word partly used). Each chain
// is modelled as a plain shift register that captures ccff_head whenever
// cfg_clk_en is high; the 8-flop model can force its tail to 0 to emulate a
// broken chain.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-flop instance
    logic       rst8, start8, verify8;
    logic [0:0] head8, tail8;
    logic       en8, busy8, done8, err8;
    logic [3:0] bits8;

    // 12-flop instance
    logic       rst12, start12, verify12;
    logic [0:0] head12, tail12;
    logic       en12, busy12, done12, err12;
    logic [3:0] bits12;

    ccff_chain_loader_if #(.WORD_W(8)) if8  ();
    ccff_chain_loader_if #(.WORD_W(8)) if12 ();

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .prog_clk   (clk),
        .pReset     (rst8),
        .start      (start8),
        .verify_en  (verify8),
        .word_if    (if8),
        .ccff_head  (head8),
        .ccff_tail  (tail8),
        .cfg_clk_en (en8),
        .busy       (busy8),
        .done       (done8),
        .error      (err8),
        .bits_sent  (bits8)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
        .prog_clk   (clk),
        .pReset     (rst12),
        .start      (start12),
        .verify_en  (verify12),
        .word_if    (if12),
        .ccff_head  (head12),
        .ccff_tail  (tail12),
        .cfg_clk_en (en12),
        .busy       (busy12),
        .done       (done12),
        .error      (err12),
        .bits_sent  (bits12)
    );

    // Chain models plus counters of enabled shifts and word handshakes.
    logic [7:0]  chain8  = '0;
    logic [11:0] chain12 = '0;
    logic        fault8  = 1'b0;
    logic        clr12   = 1'b0;
    int          enCount8 = 0, enCount12 = 0, hs8 = 0, hs12 = 0;

    assign tail8  = fault8 ? 1'b0 : chain8[7];
    assign tail12 = chain12[11];

    always @(posedge clk) begin
        if (en8) begin
            chain8   <= {chain8[6:0], head8};
            enCount8 <= enCount8 + 1;
        end
        if (if8.word_valid && if8.word_ready) hs8 <= hs8 + 1;
        if (clr12) chain12 <= '0;
        else if (en12) chain12 <= {chain12[10:0], head12};
        if (en12) enCount12 <= enCount12 + 1;
        if (if12.word_valid && if12.word_ready) hs12 <= hs12 + 1;
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse on the selected instance.
    task automatic applyStimulus(input logic is12, input logic verify);
        if (is12) begin
            start12 = 1'b1; verify12 = verify;
        end else begin
            start8 = 1'b1; verify8 = verify;
        end
        stepCycle();
        start12 = 1'b0; start8 = 1'b0;
        verify12 = 1'b0; verify8 = 1'b0;
    endtask

    // Full 12-bit load of 0xF0, 0x3C with an optional stall between words.
    task automatic load12(input int stall);
        logic [7:0] w0, w1;
        int enBase, hsBase;
        w0 = 8'hF0; w1 = 8'h3C;
        enBase = enCount12; hsBase = hs12;
        applyStimulus(1'b1, 1'b0);
        if12.word_valid = 1'b1; if12.word_data = w0;
        stepCycle();
        if12.word_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("t12 w0 head", head12, w0[7-k]);
            stepCycle();
        end
        checkOutput("t12 fetch2 bits", bits12, 8);
        for (int s = 0; s < stall; s++) begin
            checkOutput("t12 stall en", en12, 0);
            checkOutput("t12 stall ready", if12.word_ready, 1);
            stepCycle();
        end
        if12.word_valid = 1'b1; if12.word_data = w1;
        stepCycle();
        if12.word_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t12 w1 en", en12, 1);
            checkOutput("t12 w1 head", head12, w1[7-k]);
            stepCycle();
        end
        checkOutput("t12 done", done12, 1);
        checkOutput("t12 done en", en12, 0);
        checkOutput("t12 bits end", bits12, 12);
        stepCycle();
        checkOutput("t12 idle busy", busy12, 0);
        checkOutput("t12 chain", chain12, 12'hF03);
        checkOutput("t12 shifts", enCount12 - enBase, 12);
        checkOutput("t12 handshakes", hs12 - hsBase, 2);
    endtask

    initial begin
        logic [7:0] pat;
        int enBase, hsBase;

        rst8 = 1'b1; rst12 = 1'b1;
        start8 = 1'b0; start12 = 1'b0; verify8 = 1'b0; verify12 = 1'b0;
        if8.word_valid = 1'b0;  if8.word_data = '0;
        if12.word_valid = 1'b0; if12.word_data = '0;
        stepCycle();
        stepCycle();
        rst8 = 1'b0; rst12 = 1'b0;

        // Reset state
        checkOutput("rst busy", busy8, 0);
        checkOutput("rst ready", if8.word_ready, 0);
        checkOutput("rst en", en8, 0);
        checkOutput("rst head", head8, 0);
        checkOutput("rst done", done8, 0);
        checkOutput("rst error", err8, 0);
        checkOutput("rst bits", bits8, 0);

        // Single full word, no verify
        $display("[TB] load 0xA5 into 8-flop chain");
        pat = 8'hA5; enBase = enCount8; hsBase = hs8;
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1 fetch ready", if8.word_ready, 1);
        checkOutput("t1 fetch en", en8, 0);
        checkOutput("t1 fetch busy", busy8, 1);
        if8.word_valid = 1'b1; if8.word_data = pat;
        stepCycle();
        if8.word_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("t1 shift en", en8, 1);
            checkOutput("t1 shift head", head8, pat[7-k]);
            checkOutput("t1 shift ready", if8.word_ready, 0);
            stepCycle();
        end
        checkOutput("t1 done", done8, 1);
        checkOutput("t1 done en", en8, 0);
        checkOutput("t1 bits", bits8, 8);
        stepCycle();
        checkOutput("t1 done drop", done8, 0);
        checkOutput("t1 idle busy", busy8, 0);
        checkOutput("t1 chain", chain8, 8'hA5);
        checkOutput("t1 shifts", enCount8 - enBase, 8);
        checkOutput("t1 handshakes", hs8 - hsBase, 1);

        // Partial final word, then the same load with a 5-cycle stall
        $display("[TB] 12-flop chain, no stall then stall");
        load12(0);
        clr12 = 1'b1;
        stepCycle();
        clr12 = 1'b0;
        checkOutput("t12 cleared", chain12, 0);
        load12(5);

        // Verify pass on a healthy chain
        $display("[TB] verify 0x5A on healthy chain");
        pat = 8'h5A; enBase = enCount8;
        applyStimulus(1'b0, 1'b1);
        if8.word_valid = 1'b1; if8.word_data = pat;
        stepCycle();
        if8.word_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("t4 shift head", head8, pat[7-k]);
            stepCycle();
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput("t4 verify en", en8, 1);
            checkOutput("t4 verify head", head8, pat[7-k]);
            checkOutput("t4 verify bits", bits8, k);
            stepCycle();
        end
        checkOutput("t4 done", done8, 1);
        checkOutput("t4 error", err8, 0);
        stepCycle();
        checkOutput("t4 chain", chain8, 8'h5A);
        checkOutput("t4 shifts", enCount8 - enBase, 16);

        // Verify on a chain whose tail is stuck at 0; a start pulse during
        // the verify pass must be ignored
        $display("[TB] verify 0xFF on tail-stuck-at-0 chain");
        fault8 = 1'b1;
        applyStimulus(1'b0, 1'b1);
        if8.word_valid = 1'b1; if8.word_data = 8'hFF;
        stepCycle();
        if8.word_valid = 1'b0;
        for (int k = 0; k < 8; k++) stepCycle();
        checkOutput("t5 verify entry bits", bits8, 0);
        checkOutput("t5 err before compare", err8, 0);
        stepCycle();
        checkOutput("t5 err after first", err8, 1);
        for (int k = 1; k < 8; k++) begin
            start8 = (k == 3);
            stepCycle();
            if (k == 3) begin
                checkOutput("t5 busy start ignored bits", bits8, 4);
                checkOutput("t5 busy start err kept", err8, 1);
            end
        end
        start8 = 1'b0;
        checkOutput("t5 done", done8, 1);
        checkOutput("t5 err at done", err8, 1);
        stepCycle();
        checkOutput("t5 idle err sticky", err8, 1);
        checkOutput("t5 idle busy", busy8, 0);
        fault8 = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5 start clears err", err8, 0);

        // Reset in the middle of shifting, then start together with reset
        $display("[TB] reset mid-shift");
        if8.word_valid = 1'b1; if8.word_data = 8'hA5;
        stepCycle();
        if8.word_valid = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("t6 bits before rst", bits8, 3);
        checkOutput("t6 en before rst", en8, 1);
        rst8 = 1'b1;
        stepCycle();
        checkOutput("t6 rst en", en8, 0);
        checkOutput("t6 rst busy", busy8, 0);
        checkOutput("t6 rst bits", bits8, 0);
        start8 = 1'b1;
        stepCycle();
        checkOutput("t6 rst beats start", busy8, 0);
        rst8 = 1'b0; start8 = 1'b0;
        stepCycle();
        checkOutput("t6 still idle", busy8, 0);
        checkOutput("t6 still no en", en8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
